pipe_hazard_ctrl: RTL and testbench

- Central hold/flush sequencer for the 5-stage integer pipeline.
- Drives the hold/flush controls of the IF/ID, ID/EX and EX/MEM pipeline registers and the PC hold.
- Resolves four events: load-use hazards, taken jumps/branches, fixed-latency multi-cycle ops (mul/div), and data-bus wait states.
- Sits beside the pipeline. Its control outputs depend combinationally on its registered state and the current inputs.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 26 ++
 rtl/pipe_hazard_ctrl_if.sv | 39 +++
 rtl/pipe_hazard_ctrl_mc_counter.sv | 34 +++
 rtl/pipe_hazard_ctrl.sv | 119 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hold/flush sequencer.
// Also holds the load-use hazard detector used by the controller.
package pipe_ctrl_pkg;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } hz_state_e;

    localparam logic [4:0]  REG_ZERO = 5'd0;
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    // A load in EX whose result is read by the instruction in ID; x0 never creates a dependency.
    function automatic logic load_use(
        input logic       is_load,
        input logic [4:0] ex_rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       rs1_re,
        input logic       rs2_re
    );
        return is_load && (ex_rd != REG_ZERO) &&
               ((rs1_re && (rs1 == ex_rd)) || (rs2_re && (rs2 == ex_rd)));
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Control bundle between the pipeline and the hazard sequencer.
// master = pipeline side, slave = sequencer side.
interface pipe_hazard_ctrl_if;

    logic       jump_flag_i;
    logic       ex_is_load_i;
    logic [4:0] ex_rd_i;
    logic [4:0] id_rs1_i;
    logic [4:0] id_rs2_i;
    logic       id_rs1_re_i;
    logic       id_rs2_re_i;
    logic       mc_start_i;
    logic       bus_wait_i;

    logic       pc_hold_o;
    logic       ifid_hold_o;
    logic       ifid_flush_o;
    logic       idex_hold_o;
    logic       idex_flush_o;
    logic       exmem_hold_o;
    logic       exmem_flush_o;
    logic       mc_busy_o;
    logic       mc_done_o;

    modport master (
        output jump_flag_i, ex_is_load_i, ex_rd_i, id_rs1_i, id_rs2_i,
               id_rs1_re_i, id_rs2_re_i, mc_start_i, bus_wait_i,
        input  pc_hold_o, ifid_hold_o, ifid_flush_o, idex_hold_o, idex_flush_o,
               exmem_hold_o, exmem_flush_o, mc_busy_o, mc_done_o
    );

    modport slave (
        input  jump_flag_i, ex_is_load_i, ex_rd_i, id_rs1_i, id_rs2_i,
               id_rs1_re_i, id_rs2_re_i, mc_start_i, bus_wait_i,
        output pc_hold_o, ifid_hold_o, ifid_flush_o, idex_hold_o, idex_flush_o,
               exmem_hold_o, exmem_flush_o, mc_busy_o, mc_done_o
    );

endinterface

// File: rtl/pipe_hazard_ctrl_mc_counter.sv
// Loadable down-counter for multi-cycle ops: saturates at zero, holds while frozen,
// load wins over freeze.
module mc_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_freeze,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_zero
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_cnt;

    // Counter register: load, freeze, or count down towards zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= CNT_ZERO;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (!i_freeze && (r_cnt != CNT_ZERO)) begin
            r_cnt <= r_cnt - CNT_ONE;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_zero = (r_cnt == CNT_ZERO);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hold/flush sequencer for the 5-stage pipeline: load-use stalls, jump flushes,
// fixed-latency multi-cycle ops and data-bus wait states.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MC_CYCLES = 32,
    parameter int CNT_W     = 8
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave hz
);

    // The counter tracks the held MC_WAIT cycles; reaching zero marks the release cycle.
    localparam logic [CNT_W-1:0] MC_LOAD = CNT_W'(MC_CYCLES);

    hz_state_e r_state;
    hz_state_e w_state_nxt;
    logic      r_jump_pend;
    logic      w_pend_nxt;
    logic      w_cnt_load;
    logic      w_cnt_freeze;
    logic      w_cnt_zero;
    logic      w_lu;

    assign w_lu = load_use(hz.ex_is_load_i, hz.ex_rd_i, hz.id_rs1_i, hz.id_rs2_i,
                           hz.id_rs1_re_i, hz.id_rs2_re_i);

    mc_counter #(.CNT_W(CNT_W)) u_mc_counter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_freeze   (w_cnt_freeze),
        .i_load_val (MC_LOAD),
        .o_zero     (w_cnt_zero)
    );

    // State and pending-jump registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= RUN;
            r_jump_pend <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_jump_pend <= w_pend_nxt;
        end
    end

    // Next-state and control outputs; priority bus_wait > MC_WAIT > jump > load-use.
    always_comb begin
        w_state_nxt      = r_state;
        w_pend_nxt       = r_jump_pend;
        w_cnt_load       = 1'b0;
        w_cnt_freeze     = 1'b1;
        hz.pc_hold_o     = 1'b0;
        hz.ifid_hold_o   = 1'b0;
        hz.ifid_flush_o  = 1'b0;
        hz.idex_hold_o   = 1'b0;
        hz.idex_flush_o  = 1'b0;
        hz.exmem_hold_o  = 1'b0;
        hz.exmem_flush_o = 1'b0;
        hz.mc_busy_o     = 1'b0;
        hz.mc_done_o     = 1'b0;

        if (!rst) begin
            hz.ifid_flush_o  = 1'b1;
            hz.idex_flush_o  = 1'b1;
            hz.exmem_flush_o = 1'b1;
        end else if (hz.bus_wait_i) begin
            // Whole pipe frozen; a jump resolved now is replayed once the bus is ready.
            hz.pc_hold_o    = 1'b1;
            hz.ifid_hold_o  = 1'b1;
            hz.idex_hold_o  = 1'b1;
            hz.exmem_hold_o = 1'b1;
            hz.mc_busy_o    = (r_state == MC_WAIT) && !w_cnt_zero;
            w_pend_nxt      = r_jump_pend | hz.jump_flag_i;
        end else begin
            case (r_state)
                MC_WAIT: begin
                    if (w_cnt_zero) begin
                        hz.mc_done_o = 1'b1;
                        w_state_nxt  = RUN;
                    end else begin
                        hz.mc_busy_o     = 1'b1;
                        hz.pc_hold_o     = 1'b1;
                        hz.ifid_hold_o   = 1'b1;
                        hz.idex_hold_o   = 1'b1;
                        hz.exmem_flush_o = 1'b1;
                        w_cnt_freeze     = 1'b0;
                    end
                end
                RUN: begin
                    if (hz.jump_flag_i || r_jump_pend) begin
                        hz.ifid_flush_o = 1'b1;
                        hz.idex_flush_o = 1'b1;
                        w_pend_nxt      = 1'b0;
                    end else if (hz.mc_start_i) begin
                        hz.pc_hold_o     = 1'b1;
                        hz.ifid_hold_o   = 1'b1;
                        hz.idex_hold_o   = 1'b1;
                        hz.exmem_flush_o = 1'b1;
                        w_cnt_load       = 1'b1;
                        w_state_nxt      = MC_WAIT;
                    end else if (w_lu) begin
                        hz.pc_hold_o    = 1'b1;
                        hz.ifid_hold_o  = 1'b1;
                        hz.idex_flush_o = 1'b1;
                    end else begin
                        w_state_nxt = RUN;
                    end
                end
                default: begin
                    w_state_nxt = RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table, hand-written multi-cycle
// sequences, and random stimulus against a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int MC = 4;

    // Output order: pc_hold ifid_hold ifid_flush idex_hold idex_flush exmem_hold exmem_flush busy done
    localparam logic [8:0] P_IDLE  = 9'b000000000;
    localparam logic [8:0] P_RST   = 9'b001010100;
    localparam logic [8:0] P_LU    = 9'b110010000;
    localparam logic [8:0] P_JUMP  = 9'b001010000;
    localparam logic [8:0] P_START = 9'b110100100;
    localparam logic [8:0] P_BUSY  = 9'b110100110;
    localparam logic [8:0] P_DONE  = 9'b000000001;
    localparam logic [8:0] P_BUSW  = 9'b110101000;
    localparam logic [8:0] P_BUSWB = 9'b110101010;

    typedef struct packed {
        logic       rst;
        logic       jump;
        logic       load;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       re1;
        logic       re2;
        logic       start;
        logic       bus;
    } in_t;

    typedef struct packed {
        in_t        in;
        logic [8:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    bit   m_in_op = 1'b0;
    int   m_left  = 0;
    bit   m_pend  = 1'b0;

    vec_t tbl [10];

    pipe_hazard_ctrl_if hz();

    pipe_hazard_ctrl #(.MC_CYCLES(MC), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    always #5 clk = ~clk;

    function automatic in_t mk(input bit jump, input bit load, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input bit re1, input bit re2, input bit start, input bit bus);
        in_t v;
        v.rst = 1'b1; v.jump = jump; v.load = load; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.re1 = re1; v.re2 = re2; v.start = start; v.bus = bus;
        return v;
    endfunction

    function automatic in_t idle();
        return mk(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic bit lu_of(input in_t v);
        return v.load && (v.rd != 5'd0) && ((v.re1 && v.rs1 == v.rd) || (v.re2 && v.rs2 == v.rd));
    endfunction

    // Expected outputs: a multi-cycle op stays busy for MC cycles after its start, then releases.
    function automatic logic [8:0] model_out(input in_t v);
        if (!v.rst) return P_RST;
        if (v.bus) return (m_in_op && m_left > 0) ? P_BUSWB : P_BUSW;
        if (m_in_op) return (m_left > 0) ? P_BUSY : P_DONE;
        if (v.jump || m_pend) return P_JUMP;
        if (v.start) return P_START;
        if (lu_of(v)) return P_LU;
        return P_IDLE;
    endfunction

    task automatic model_step(input in_t v);
        if (!v.rst) begin
            m_in_op = 1'b0; m_left = 0; m_pend = 1'b0;
        end else if (v.bus) begin
            m_pend = m_pend | v.jump;
        end else if (m_in_op) begin
            if (m_left > 0) m_left = m_left - 1;
            else m_in_op = 1'b0;
        end else if (v.jump || m_pend) begin
            m_pend = 1'b0;
        end else if (v.start) begin
            m_in_op = 1'b1; m_left = MC;
        end
    endtask

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input in_t v, input string name, input bit use_tab, input logic [8:0] tab);
        logic [8:0] act;
        @(negedge clk);
        rst             = v.rst;
        hz.jump_flag_i  = v.jump;
        hz.ex_is_load_i = v.load;
        hz.ex_rd_i      = v.rd;
        hz.id_rs1_i     = v.rs1;
        hz.id_rs2_i     = v.rs2;
        hz.id_rs1_re_i  = v.re1;
        hz.id_rs2_re_i  = v.re2;
        hz.mc_start_i   = v.start;
        hz.bus_wait_i   = v.bus;
        #1;
        act = {hz.pc_hold_o, hz.ifid_hold_o, hz.ifid_flush_o, hz.idex_hold_o, hz.idex_flush_o,
               hz.exmem_hold_o, hz.exmem_flush_o, hz.mc_busy_o, hz.mc_done_o};
        check(name, act, use_tab ? tab : model_out(v));
        check({name, "_hold_flush_excl"},
              {6'd0, act[7] & act[6], act[5] & act[4], act[3] & act[2]}, 9'd0);
        model_step(v);
    endtask

    initial begin
        in_t v;
        in_t r;

        tbl[0] = '{in: idle(),                                                    exp: P_IDLE};
        tbl[1] = '{in: mk(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0), exp: P_LU};
        tbl[2] = '{in: mk(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0), exp: P_IDLE};
        tbl[3] = '{in: mk(1'b0, 1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0), exp: P_LU};
        tbl[4] = '{in: mk(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0), exp: P_IDLE};
        tbl[5] = '{in: mk(1'b0, 1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0), exp: P_IDLE};
        tbl[6] = '{in: mk(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0), exp: P_JUMP};
        tbl[7] = '{in: mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0), exp: P_JUMP};
        tbl[8] = '{in: mk(1'b0, 1'b1, 5'd5, 5'd6, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0), exp: P_IDLE};
        tbl[9] = '{in: mk(1'b0, 1'b1, 5'd31, 5'd31, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0), exp: P_LU};

        r = idle();
        r.rst = 1'b0;
        rst = 1'b0;
        hz.jump_flag_i = 1'b0; hz.ex_is_load_i = 1'b0; hz.ex_rd_i = 5'd0;
        hz.id_rs1_i = 5'd0; hz.id_rs2_i = 5'd0; hz.id_rs1_re_i = 1'b0; hz.id_rs2_re_i = 1'b0;
        hz.mc_start_i = 1'b0; hz.bus_wait_i = 1'b0;

        for (int i = 0; i < 3; i++) step(r, "reset", 1'b1, P_RST);
        step(idle(), "after_reset", 1'b1, P_IDLE);

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].in, $sformatf("vec%0d", i), 1'b1, tbl[i].exp);
        end

        // Multi-cycle op: start at cycle 0, busy 1..MC, done at MC+1.
        v = idle(); v.start = 1'b1;
        step(v, "mc_start", 1'b1, P_START);
        for (int i = 1; i <= MC; i++) step(idle(), $sformatf("mc_busy_c%0d", i), 1'b1, P_BUSY);
        step(idle(), "mc_done", 1'b1, P_DONE);
        step(idle(), "mc_after", 1'b1, P_IDLE);

        // Bus wait for 3 cycles from cycle 2 delays done to cycle 8.
        step(v, "bw_start", 1'b1, P_START);
        step(idle(), "bw_c1", 1'b1, P_BUSY);
        for (int i = 2; i <= 4; i++) begin
            r = idle(); r.bus = 1'b1;
            step(r, $sformatf("bw_wait_c%0d", i), 1'b1, P_BUSWB);
        end
        for (int i = 5; i <= 7; i++) step(idle(), $sformatf("bw_busy_c%0d", i), 1'b1, P_BUSY);
        step(idle(), "bw_done_c8", 1'b1, P_DONE);
        step(idle(), "bw_after", 1'b1, P_IDLE);

        // Jump seen during bus wait is replayed on the first free cycle, then cleared.
        r = idle(); r.bus = 1'b1; r.jump = 1'b1;
        step(r, "jbw_wait", 1'b1, P_BUSW);
        r.jump = 1'b0;
        step(r, "jbw_wait2", 1'b1, P_BUSW);
        step(idle(), "jbw_flush", 1'b1, P_JUMP);
        step(idle(), "jbw_cleared", 1'b1, P_IDLE);

        // Reset while the counter is at 2: immediate release, no done pulse afterwards.
        step(v, "rmo_start", 1'b1, P_START);
        for (int i = 1; i <= 2; i++) step(idle(), $sformatf("rmo_busy_c%0d", i), 1'b1, P_BUSY);
        r = idle(); r.rst = 1'b0;
        step(r, "rmo_reset", 1'b1, P_RST);
        step(r, "rmo_reset2", 1'b1, P_RST);
        for (int i = 0; i < 6; i++) step(idle(), $sformatf("rmo_after%0d", i), 1'b1, P_IDLE);

        // Random traffic against the model; jump is never raised during a multi-cycle op.
        for (int i = 0; i < 600; i++) begin
            v = idle();
            v.load  = ($urandom_range(0, 1) == 1);
            v.rd    = 5'($urandom_range(0, 3));
            v.rs1   = 5'($urandom_range(0, 3));
            v.rs2   = 5'($urandom_range(0, 3));
            v.re1   = ($urandom_range(0, 1) == 1);
            v.re2   = ($urandom_range(0, 1) == 1);
            v.jump  = ($urandom_range(0, 5) == 0) && !m_in_op;
            v.start = ($urandom_range(0, 9) == 0);
            v.bus   = ($urandom_range(0, 4) == 0);
            step(v, "rand", 1'b0, P_IDLE);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
